mole_hit_scorer: RTL

MOLE_HIT_SCORER -- requirements
Module: mole_hit_scorer

---
 rtl/mole_hit_scorer.sv | 77 +++++++
 1 files changed

// File: rtl/mole_hit_scorer.sv
// mole_hit_scorer: debounced whack-a-mole key judge with saturating hit/miss counters.
module mole_hit_scorer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCORE_W         = 8
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic [3:0]         KEY,
  input  logic [3:0]         mole,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic               armed
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;
  logic [3:0]         r_sync1, r_sync2, r_stable, r_stable_d, r_press, r_mole_q;
  logic [CW-1:0]      r_cnt [4];
  state_t             r_state, w_eff, w_next;
  logic               r_hit, r_miss, r_armed, w_change, w_hit, w_miss;
  logic [SCORE_W-1:0] r_score, r_misses;
  // Press is registered once more after the stable-level edge so a key low
  // held from edge N is judged on edge N+DEBOUNCE_CYCLES+3.
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      r_sync1    <= '1;
      r_sync2    <= '1;
      r_stable   <= '1;
      r_stable_d <= '1;
      r_press    <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1    <= KEY;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_press    <= r_stable_d & ~r_stable;
      for (int i = 0; i < 4; i++)
        if (r_sync2[i] == r_stable[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == CMAX) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  // A mole change retargets the FSM before the same-cycle press is judged.
  always_comb begin
    w_change = mole != r_mole_q;
    w_eff    = w_change ? (|mole ? ARMED : IDLE) : r_state;
    w_hit    = w_eff == ARMED && |(r_press & mole);
    w_miss   = |r_press && !w_hit && w_eff != LOCKED;
    w_next   = w_hit ? LOCKED : w_eff;
  end
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      r_state  <= IDLE;
      r_mole_q <= '0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_armed  <= 1'b0;
      r_score  <= '0;
      r_misses <= '0;
    end else begin
      r_state  <= w_next;
      r_mole_q <= mole;
      r_hit    <= w_hit;
      r_miss   <= w_miss;
      r_armed  <= r_state == ARMED;
      r_score  <= (w_hit && r_score != '1) ? r_score + 1'b1 : r_score;
      r_misses <= (w_miss && r_misses != '1) ? r_misses + 1'b1 : r_misses;
    end
  assign hit    = r_hit;
  assign miss   = r_miss;
  assign armed  = r_armed;
  assign score  = r_score;
  assign misses = r_misses;
endmodule
